// File: rtl/flag_branch_resolver.sv
// Purpose : resolves B / CBZ / CBNZ / B.cond from stored or same-cycle forwarded
//           {N,V,C} flags, registers the taken target, pulses a fetch redirect and
//           holds flush high for FLUSH_CYCLES cycles while younger fetches drain.
// Latency : branch sampled at edge k -> redirect/br_target valid in the cycle after k.
// Backpressure: none; branches presented while flushing are squashed (dropped).
// Ports   : clk, reset (async, active-high)
//           flags_q/flag_wr_en/flags_new - stored flags, same-cycle write bypass
//           zero                         - CBZ/CBNZ operand is zero
//           br_valid/br_kind/br_pc/br_imm - branch under evaluation
//           redirect/br_target/flush/taken_count - PC-select and squash outputs
module flag_branch_resolver #(
  parameter int PC_W         = 64,
  parameter int IMM_W        = 26,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       flags_q,
  input  logic             flag_wr_en,
  input  logic [2:0]       flags_new,
  input  logic             zero,
  input  logic             br_valid,
  input  logic [3:0]       br_kind,
  input  logic [PC_W-1:0]  br_pc,
  input  logic [IMM_W-1:0] br_imm,
  output logic             redirect,
  output logic [PC_W-1:0]  br_target,
  output logic             flush,
  output logic [CNT_W-1:0] taken_count
);

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  // Counter is loaded with FLUSH_CYCLES-1 so FLUSH lasts exactly FLUSH_CYCLES cycles.
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);

  state_t            state_q, state_d;
  logic [2:0]        fcnt_q, fcnt_d;
  logic              redirect_q, redirect_d;
  logic [PC_W-1:0]   target_q, target_d;
  logic [CNT_W-1:0]  count_q, count_d;

  logic [2:0]        eff_flags;
  logic              flag_n, flag_v, flag_c;
  logic              cond_met;
  logic [PC_W-1:0]   imm_ext;
  logic [PC_W-1:0]   target_calc;

  // A flag write in the same cycle is newer than the register contents.
  assign eff_flags = flag_wr_en ? flags_new : flags_q;
  assign flag_n    = eff_flags[2];
  assign flag_v    = eff_flags[1];
  assign flag_c    = eff_flags[0];

  always_comb begin
    cond_met = 1'b0;
    case (br_kind)
      4'd0:    cond_met = 1'b1;              // B
      4'd1:    cond_met = zero;              // CBZ
      4'd2:    cond_met = ~zero;             // CBNZ
      4'd3:    cond_met = flag_n ^ flag_v;   // LT
      4'd4:    cond_met = ~(flag_n ^ flag_v);// GE
      4'd5:    cond_met = flag_c;            // HS
      4'd6:    cond_met = ~flag_c;           // LO
      4'd7:    cond_met = flag_n;            // MI
      4'd8:    cond_met = ~flag_n;           // PL
      4'd9:    cond_met = flag_v;            // VS
      4'd10:   cond_met = ~flag_v;           // VC
      default: cond_met = 1'b0;              // reserved: never taken
    endcase
  end

  // Word offset -> byte offset; addition wraps modulo 2^PC_W.
  assign imm_ext     = {{(PC_W-IMM_W){br_imm[IMM_W-1]}}, br_imm};
  assign target_calc = br_pc + (imm_ext << 2);

  always_comb begin
    state_d    = state_q;
    fcnt_d     = fcnt_q;
    redirect_d = 1'b0;
    target_d   = target_q;
    count_d    = count_q;
    case (state_q)
      IDLE: begin
        if (br_valid && cond_met) begin
          target_d   = target_calc;
          redirect_d = 1'b1;
          fcnt_d     = FLUSH_INIT;
          state_d    = FLUSH;
          if (count_q != {CNT_W{1'b1}}) begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      FLUSH: begin
        // Branches seen here are younger than the redirect and are dropped,
        // including on the edge that returns to IDLE.
        if (fcnt_q == 3'd0) begin
          state_d = IDLE;
        end else begin
          fcnt_d = fcnt_q - 3'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      fcnt_q     <= 3'd0;
      redirect_q <= 1'b0;
      target_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      fcnt_q     <= fcnt_d;
      redirect_q <= redirect_d;
      target_q   <= target_d;
      count_q    <= count_d;
    end
  end

  assign redirect    = redirect_q;
  assign br_target   = target_q;
  assign flush       = (state_q == FLUSH);
  assign taken_count = count_q;

endmodule
